// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and memory-write / status output bundle for uart_frame_decoder.
//   in_valid   : one-cycle strobe, in_data holds a received byte
//   in_data    : received byte
//   in_err     : one-cycle strobe, receiver framing/parity error
//   wr_en      : one-cycle write strobe
//   wr_addr    : write address (held while wr_en is low)
//   wr_data    : write data (held while wr_en is low)
//   frame_done : one-cycle pulse, frame received with good checksum
//   frame_err  : one-cycle pulse, frame aborted or checksum bad
//   busy       : high while a frame is in progress
// The master modport is the byte source and write consumer; the slave modport is the decoder.
interface uart_frame_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_err;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  modport master (
    output in_valid, in_data, in_err,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_err,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Command front-end of the bootstrap loader. Hunts for SYNC_BYTE in the received byte stream and
// parses write frames: SYNC, ADDR_HI, ADDR_LO, LEN, LEN data bytes, CSUM. Each data byte produces
// one registered memory write to consecutive (wrapping) addresses; the frame result is reported
// as a one-cycle frame_done / frame_err pulse.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_frame_decoder_if slave modport (byte input, write and status outputs)
module uart_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 2000
) (
  input logic                  clk,
  input logic                  rst,
  uart_frame_decoder_if.slave  bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StHunt, StAddrHi, StAddrLo, StLen, StData, StCsum} state_e;

  state_e            r_state, w_state_nx;
  logic [15:0]       r_addr, w_addr_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic [7:0]        r_sum, w_sum_nx;
  logic [TmoW-1:0]   r_tmo, w_tmo_nx;
  logic              r_wr_en, w_wr_en_nx;
  logic [15:0]       r_wr_addr, w_wr_addr_nx;
  logic [7:0]        r_wr_data, w_wr_data_nx;
  logic              r_done, w_done_nx;
  logic              r_err, w_err_nx;
  logic              r_busy, w_busy_nx;
  logic [7:0]        w_total;

  // Running checksum including the byte currently on the input.
  assign w_total = r_sum + bus.in_data;

  always_comb begin
    w_state_nx   = r_state;
    w_addr_nx    = r_addr;
    w_cnt_nx     = r_cnt;
    w_sum_nx     = r_sum;
    w_tmo_nx     = bus.in_valid ? '0 : r_tmo + TmoW'(1);
    w_wr_en_nx   = 1'b0;
    w_wr_addr_nx = r_wr_addr;
    w_wr_data_nx = r_wr_data;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;

    if (bus.in_err) begin
      // Receiver error aborts a frame in progress; in HUNT the byte (if any) is simply dropped.
      if (r_state != StHunt) begin
        w_state_nx = StHunt;
        w_err_nx   = 1'b1;
      end
    end else if (bus.in_valid) begin
      unique case (r_state)
        StHunt: begin
          if (bus.in_data == SYNC_BYTE) begin
            w_state_nx = StAddrHi;
            w_sum_nx   = 8'h00;
          end
        end
        StAddrHi: begin
          w_addr_nx  = {bus.in_data, r_addr[7:0]};
          w_sum_nx   = w_total;
          w_state_nx = StAddrLo;
        end
        StAddrLo: begin
          w_addr_nx  = {r_addr[15:8], bus.in_data};
          w_sum_nx   = w_total;
          w_state_nx = StLen;
        end
        StLen: begin
          w_cnt_nx   = bus.in_data;
          w_sum_nx   = w_total;
          w_state_nx = (bus.in_data == 8'h00) ? StCsum : StData;
        end
        StData: begin
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = r_addr;
          w_wr_data_nx = bus.in_data;
          w_addr_nx    = r_addr + 16'd1;
          w_sum_nx     = w_total;
          w_cnt_nx     = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nx = StCsum;
        end
        StCsum: begin
          w_state_nx = StHunt;
          w_done_nx  = (w_total == 8'h00);
          w_err_nx   = (w_total != 8'h00);
        end
        default: w_state_nx = StHunt;
      endcase
    end else if (r_state != StHunt && r_tmo == TmoW'(TIMEOUT)) begin
      w_state_nx = StHunt;
      w_err_nx   = 1'b1;
    end

    // Idle gap counter only runs inside a frame.
    if (w_state_nx == StHunt) w_tmo_nx = '0;
    w_busy_nx = (w_state_nx != StHunt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StHunt;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_tmo     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_addr    <= w_addr_nx;
      r_cnt     <= w_cnt_nx;
      r_sum     <= w_sum_nx;
      r_tmo     <= w_tmo_nx;
      r_wr_en   <= w_wr_en_nx;
      r_wr_addr <= w_wr_addr_nx;
      r_wr_data <= w_wr_data_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_busy    <= w_busy_nx;
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: a frame-level reference model turns each stimulus
// cycle into expected write/result events and busy values; a negedge monitor pops and compares.
module tb_uart_frame_decoder;

  localparam int unsigned TMO  = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  localparam logic [2:0] KWr   = 3'b100;
  localparam logic [2:0] KDone = 3'b010;
  localparam logic [2:0] KErr  = 3'b001;

  typedef struct {
    int          due;
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    int   due;
    logic busy;
  } busy_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ev_t   ev_q[$];
  busy_t bq[$];

  // Reference model state: inside a frame or not, bytes collected after SYNC, idle cycles.
  bit         m_in_frame = 1'b0;
  logic [7:0] m_fb[$];
  int         m_idle = 0;

  logic [15:0] hold_addr = '0;
  logic [7:0]  hold_data = '0;

  uart_frame_decoder_if u_if ();

  uart_frame_decoder #(
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TMO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.due  = cyc + 1;
    e.kind = k;
    e.addr = a;
    e.data = d;
    ev_q.push_back(e);
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d, input bit e);
    busy_t b;
    if (m_in_frame && e) begin
      push_ev(KErr, '0, '0);
      m_in_frame = 1'b0;
    end else if (v && !e) begin
      if (!m_in_frame) begin
        if (d == SYNC) begin
          m_in_frame = 1'b1;
          m_fb.delete();
          m_idle = 0;
        end
      end else begin
        m_fb.push_back(d);
        m_idle = 0;
        if (m_fb.size() >= 4) begin
          int len;
          len = int'(m_fb[2]);
          if (m_fb.size() <= len + 3) begin
            logic [15:0] a;
            a = {m_fb[0], m_fb[1]} + 16'(m_fb.size() - 4);
            push_ev(KWr, a, d);
          end else begin
            int s;
            s = 0;
            foreach (m_fb[i]) s += int'(m_fb[i]);
            push_ev(((s % 256) == 0) ? KDone : KErr, '0, '0);
            m_in_frame = 1'b0;
          end
        end
      end
    end else if (!v && m_in_frame) begin
      m_idle++;
      if (m_idle > TMO) begin
        push_ev(KErr, '0, '0);
        m_in_frame = 1'b0;
      end
    end
    b.due  = cyc + 1;
    b.busy = m_in_frame;
    bq.push_back(b);
  endfunction

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit e);
    @(posedge clk);
    #1;
    rst            = r;
    u_if.in_valid  = v;
    u_if.in_data   = d;
    u_if.in_err    = e;
    if (r) begin
      m_in_frame = 1'b0;
      ev_q.delete();
      bq.delete();
    end else begin
      model_step(v, d, e);
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) drive(1'b0, 1'b1, s[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: compare outputs against the expected event and busy queues.
  always @(negedge clk) begin
    logic [2:0] obs;
    ev_t        e;
    busy_t      b;
    obs = {u_if.wr_en, u_if.frame_done, u_if.frame_err};
    if (rst) begin
      n_checks++;
      if (obs != 3'b000 || u_if.busy || u_if.wr_addr != 16'h0 || u_if.wr_data != 8'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got ev=%b busy=%b addr=%h data=%h want all zero",
                 cyc, obs, u_if.busy, u_if.wr_addr, u_if.wr_data);
      end
      hold_addr = '0;
      hold_data = '0;
    end else begin
      if (ev_q.size() != 0 && ev_q[0].due == cyc) begin
        e = ev_q.pop_front();
        n_checks++;
        if (obs != e.kind || (e.kind == KWr && (u_if.wr_addr != e.addr || u_if.wr_data != e.data)))
        begin
          n_fail++;
          $display("FAIL event cyc=%0d got ev=%b addr=%h data=%h want ev=%b addr=%h data=%h",
                   cyc, obs, u_if.wr_addr, u_if.wr_data, e.kind, e.addr, e.data);
        end
        if (e.kind == KWr) begin
          hold_addr = e.addr;
          hold_data = e.data;
        end
      end else begin
        n_checks++;
        if (obs != 3'b000 || u_if.wr_addr != hold_addr || u_if.wr_data != hold_data) begin
          n_fail++;
          $display("FAIL quiet cyc=%0d got ev=%b addr=%h data=%h want ev=000 addr=%h data=%h",
                   cyc, obs, u_if.wr_addr, u_if.wr_data, hold_addr, hold_data);
        end
      end
      if (bq.size() != 0 && bq[0].due == cyc) begin
        b = bq.pop_front();
        n_checks++;
        if (u_if.busy !== b.busy) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got %b want %b", cyc, u_if.busy, b.busy);
        end
      end
    end
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] fr[$];
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    u_if.in_err   = 1'b0;

    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Good frame, two writes.
    s = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB9};
    send_seq(s);
    // Same frame with bad checksum.
    s = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB8};
    send_seq(s);
    // Zero-length frame, then junk and an address-wrapping frame.
    s = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'hF0, 8'h00, 8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h02,
          8'hFD};
    send_seq(s);
    idle(2);

    // Timeout expiry, then a byte landing on the exact expiry cycle.
    s = '{8'hA5, 8'h12};
    send_seq(s);
    idle(TMO + 3);
    send_seq(s);
    idle(TMO);
    s = '{8'h34, 8'h00, 8'hBA};
    send_seq(s);
    s = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB9};
    send_seq(s);

    // in_err with in_valid mid-frame, then in_err alone in HUNT.
    s = '{8'hA5, 8'h12, 8'h34, 8'h03, 8'h11};
    send_seq(s);
    drive(1'b0, 1'b1, 8'h22, 1'b1);
    drive(1'b0, 1'b1, 8'h33, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(3);

    // Reset in the middle of DATA, with a data byte in the same cycle.
    s = '{8'hA5, 8'h12, 8'h34, 8'h04, 8'h01, 8'h02};
    send_seq(s);
    drive(1'b1, 1'b1, 8'h03, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    s = '{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB9};
    send_seq(s);

    // Randomized frames with gaps, junk, corrupted checksums and receiver errors.
    for (int f = 0; f < 60; f++) begin
      logic [15:0] a;
      int          len;
      int          sum;
      fr.delete();
      if ($urandom_range(0, 3) == 0) fr.push_back(8'($urandom_range(0, 255)));
      a   = 16'($urandom);
      len = $urandom_range(0, 6);
      fr.push_back(SYNC);
      fr.push_back(a[15:8]);
      fr.push_back(a[7:0]);
      fr.push_back(8'(len));
      for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
      sum = 0;
      for (int k = fr.size() - len - 3; k < fr.size(); k++) sum += int'(fr[k]);
      fr.push_back(8'(256 - (sum % 256)) + (($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00));
      foreach (fr[k]) begin
        int r;
        r = $urandom_range(0, 99);
        if (r >= 80 && r < 92) idle($urandom_range(1, 4));
        else if (r >= 92 && r < 96) idle(TMO);
        else if (r >= 96) idle(TMO + 1);
        if ($urandom_range(0, 59) == 0) drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, fr[k], ($urandom_range(0, 59) == 0));
      end
    end

    idle(TMO + 4);
    n_checks++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending events want 0", ev_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
